// File: rtl/frame_demux_pkg.sv
// ---------------------------------------------------------------------------
// frame_demux_pkg
//   Shared definitions for the packet-framing demux.
//   - K-character codes of the recognised control set
//   - FSM state encoding of the framer
//   - FIFO entry layout {err, eop, sop, data[7:0]} (11 bits)
//   - classify(): maps a (k, value) symbol to a framing class
// ---------------------------------------------------------------------------
package frame_demux_pkg;

    // Recognised K-characters
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_COM = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_OSET = 2'd2
    } state_t;

    // One FIFO word; err is the most significant bit
    typedef struct packed {
        logic       err;
        logic       eop;
        logic       sop;
        logic [7:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Framing class of an incoming symbol
    typedef enum logic [2:0] {
        SYM_DATA  = 3'd0,   // k=0
        SYM_START = 3'd1,   // STP or SDP
        SYM_END   = 3'd2,   // END
        SYM_EDB   = 3'd3,   // EDB (end, bad)
        SYM_COM   = 3'd4,   // COM (ordered-set lead)
        SYM_FILL  = 3'd5,   // SKP / IDL / FTS
        SYM_BADK  = 3'd6    // K value outside the control set
    } sym_class_t;

    function automatic sym_class_t classify(input logic is_k, input logic [7:0] sym);
        sym_class_t c;
        if (!is_k) begin
            c = SYM_DATA;
        end else begin
            case (sym)
                K_STP, K_SDP:        c = SYM_START;
                K_END:               c = SYM_END;
                K_EDB:               c = SYM_EDB;
                K_COM:               c = SYM_COM;
                K_SKP, K_IDL, K_FTS: c = SYM_FILL;
                default:             c = SYM_BADK;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_demux_sym_fifo.sv
// ---------------------------------------------------------------------------
// sym_fifo
//   Synchronous show-ahead FIFO. The head entry is presented on 'head'
//   whenever 'valid' is high; an entry written at edge M is visible right
//   after edge M. Push and pop in the same cycle are both honoured, also
//   when full.
//
//   Ports
//     clk, reset       clock, asynchronous active-high reset
//     push, push_data  write request and word
//     pop              read request (effective only while valid)
//     head             head word (all zero while empty)
//     valid            FIFO non-empty (registered)
//     full             FIFO holds DEPTH entries (registered)
//     accept           combinational: this cycle's push is stored
//     drop             registered one-cycle pulse: a push was lost
// ---------------------------------------------------------------------------
module sym_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic             accept,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             valid_reg, full_reg, drop_reg;
    logic             do_pop, do_push;

    assign do_pop  = pop & valid_reg;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full_reg | do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
            drop_reg   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            // Flags are registered from the next occupancy so they line up
            // with count_reg without a decode path on the outputs
            valid_reg <= (count_next != '0);
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            drop_reg  <= push & ~do_push;
        end
    end

    // Storage carries no reset; stale words are masked by the valid gate
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head   = valid_reg ? mem[rd_ptr_reg] : '0;
    assign valid  = valid_reg;
    assign full   = full_reg;
    assign accept = do_push;
    assign drop   = drop_reg;

endmodule

// File: rtl/frame_demux.sv
// ---------------------------------------------------------------------------
// frame_demux
//   Packet framer between the symbol decoder and the packet layer. Tracks
//   STP/SDP ... END/EDB framing and COM-led ordered sets, strips control
//   symbols and queues packet bytes with sop/eop/err markers in a show-ahead
//   FIFO with ready/valid backpressure.
//
//   Each data byte is held one symbol in 'pend' so the following symbol can
//   decide whether it is the last byte of the packet.
//
//   Optional feature: define STATS_EN to add saturating pkt_count/err_count.
//
//   Ports
//     clk, reset                     clock, asynchronous active-high reset
//     valid_in, k_in, data_in        incoming symbol
//     ready_in                       downstream accepts FIFO head
//     valid_out, data_out            FIFO head
//     sop_out, eop_out, err_out      head markers (qualified by valid_out)
//     control                        last recognised control symbol
//     fifo_full                      FIFO holds DEPTH entries
//     drop                           one-cycle pulse: entry lost to overflow
//     pkt_count, err_count           (STATS_EN) eop / errored-eop pushes
// ---------------------------------------------------------------------------
module frame_demux
    import frame_demux_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             k_in,
    input  logic [7:0]       data_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [7:0]       data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             err_out,
    output logic [7:0]       control,
    output logic             fifo_full,
    output logic             drop
`ifdef STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
`endif
);

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("frame_demux: DEPTH must be a power of two >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("frame_demux: CNT_W must be >= 1");
    end

    sym_class_t sym;
    state_t     state_reg, state_next;
    logic       pend_valid_reg, pend_valid_next;
    logic [7:0] pend_data_reg, pend_data_next;
    logic       pend_sop_reg, pend_sop_next;
    logic       sop_arm_reg, sop_arm_next;
    logic       ovf_reg, ovf_next;
    logic [7:0] control_reg;

    logic       push, push_eop, push_err;
    logic       fifo_accept;
    entry_t     push_entry, head_entry;

    assign sym = classify(k_in, data_in);

    // -----------------------------------------------------------------------
    // Framing FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            pend_sop_reg   <= 1'b0;
            sop_arm_reg    <= 1'b0;
            ovf_reg        <= 1'b0;
            control_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
            pend_sop_reg   <= pend_sop_next;
            sop_arm_reg    <= sop_arm_next;
            ovf_reg        <= ovf_next;
            if (valid_in && k_in && sym != SYM_BADK) control_reg <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM: next state and push request
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pend_valid_next = pend_valid_reg;
        pend_data_next  = pend_data_reg;
        pend_sop_next   = pend_sop_reg;
        sop_arm_next    = sop_arm_reg;
        push            = 1'b0;
        push_eop        = 1'b0;
        push_err        = 1'b0;

        if (valid_in) begin
            case (state_reg)
                ST_IDLE: begin
                    case (sym)
                        SYM_START: begin
                            state_next   = ST_PKT;
                            sop_arm_next = 1'b1;
                        end
                        SYM_COM:  state_next = ST_OSET;
                        default:  state_next = ST_IDLE;
                    endcase
                end

                ST_PKT: begin
                    case (sym)
                        SYM_DATA: begin
                            // Previous byte is known not to be last
                            push            = pend_valid_reg;
                            pend_valid_next = 1'b1;
                            pend_data_next  = data_in;
                            pend_sop_next   = sop_arm_reg;
                            sop_arm_next    = 1'b0;
                        end
                        SYM_END: begin
                            push            = pend_valid_reg;
                            push_eop        = 1'b1;
                            pend_valid_next = 1'b0;
                            state_next      = ST_IDLE;
                        end
                        default: begin
                            // EDB, or any framing violation: close the packet bad
                            push            = pend_valid_reg;
                            push_eop        = 1'b1;
                            push_err        = 1'b1;
                            pend_valid_next = 1'b0;
                            case (sym)
                                SYM_START: begin
                                    state_next   = ST_PKT;
                                    sop_arm_next = 1'b1;
                                end
                                SYM_COM:  state_next = ST_OSET;
                                default:  state_next = ST_IDLE;
                            endcase
                        end
                    endcase
                end

                ST_OSET: begin
                    case (sym)
                        SYM_COM, SYM_FILL: state_next = ST_OSET;
                        SYM_START: begin
                            state_next   = ST_PKT;
                            sop_arm_next = 1'b1;
                        end
                        default:           state_next = ST_IDLE;
                    endcase
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Overflow tracking: once an entry is lost, the next stored eop entry is
    // marked bad so the packet layer discards the damaged packet.
    // -----------------------------------------------------------------------
    always_comb begin
        ovf_next = ovf_reg;
        if (push && !fifo_accept) begin
            ovf_next = 1'b1;
        end else if (fifo_accept && push_eop) begin
            ovf_next = 1'b0;
        end
    end

    assign push_entry.err  = push_err | (push_eop & ovf_reg);
    assign push_entry.eop  = push_eop;
    assign push_entry.sop  = pend_sop_reg;
    assign push_entry.data = pend_data_reg;

    sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (ready_in),
        .head      (head_entry),
        .valid     (valid_out),
        .full      (fifo_full),
        .accept    (fifo_accept),
        .drop      (drop)
    );

    assign data_out = head_entry.data;
    assign sop_out  = head_entry.sop;
    assign eop_out  = head_entry.eop;
    assign err_out  = head_entry.err;
    assign control  = control_reg;

`ifdef STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics over stored eop entries
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] pkt_count_reg, err_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_reg <= '0;
            err_count_reg <= '0;
        end else if (fifo_accept && push_eop) begin
            if (pkt_count_reg != '1) pkt_count_reg <= pkt_count_reg + CNT_W'(1);
            if (push_entry.err && err_count_reg != '1)
                err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign pkt_count = pkt_count_reg;
    assign err_count = err_count_reg;
`endif

endmodule
